pref_issue_sched: RTL

PREF_ISSUE_SCHED -- requirements
Module: pref_issue_sched

---
 rtl/pref_sched_pkg.sv | 28 ++
 rtl/pref_sched_fifo.sv | 68 ++++++
 rtl/pref_issue_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pref_sched_pkg.sv
// Shared types, defaults and helpers for the prefetch issue scheduler.
package pref_sched_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_LINE_BYTES = 64;
    localparam int unsigned CNT_W              = 16;
    localparam int unsigned ADDR_W             = 64;
    localparam int unsigned NUM_SLOTS          = 3;

    typedef logic [ADDR_W-1:0] line_addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Clear the in-line offset bits; line_bytes must be a power of two.
    function automatic line_addr_t line_align(input line_addr_t addr,
                                              input int unsigned line_bytes);
        line_addr_t mask;
        mask = ~(line_addr_t'(line_bytes) - line_addr_t'(1));
        return addr & mask;
    endfunction

    // Add 0..3 to a counter, sticking at all-ones.
    function automatic cnt_t sat_add(input cnt_t cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W - 1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pref_sched_fifo.sv
// Circular line-address queue: 0..3 pushes and at most one pop per cycle.
// Exposes every entry plus a valid mask so the parent can search for duplicates.
module pref_sched_fifo
    import pref_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic [1:0]                      push_cnt,
    input  line_addr_t [NUM_SLOTS-1:0]      push_data,
    input  logic                            pop,
    output line_addr_t                      head,
    output logic [$clog2(DEPTH):0]          occupancy,
    output line_addr_t [DEPTH-1:0]          entries,
    output logic [DEPTH-1:0]                entry_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    line_addr_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]          rptr_q;
    logic [PW-1:0]          wptr_q;
    logic [OW-1:0]          occ_q;

    // Write accepted lines into consecutive slots from the write pointer (wraps naturally).
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (2'(k) < push_cnt) begin
                    mem_q[wptr_q + PW'(k)] <= push_data[k];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the queue without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
        end else if (clr) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
        end else begin
            rptr_q <= rptr_q + PW'(pop);
            wptr_q <= wptr_q + PW'(push_cnt);
            occ_q  <= occ_q + OW'(push_cnt) - OW'(pop);
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PW'(i) - rptr_q} < occ_q;
        end
    end

    assign head      = mem_q[rptr_q];
    assign occupancy = occ_q;
    assign entries   = mem_q;

endmodule

// File: rtl/pref_issue_sched.sv
// Prefetch issue scheduler: aligns up to three candidate addresses per cycle,
// drops duplicates and overflow, queues the rest and issues one line per handshake.
module pref_issue_sched
    import pref_sched_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned LINE_BYTES = DEFAULT_LINE_BYTES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        pref_addr1_i,
    input  logic [ADDR_W-1:0]        pref_addr2_i,
    input  logic [ADDR_W-1:0]        pref_addr3_i,
    input  logic                     pref_valid1_i,
    input  logic                     pref_valid2_i,
    input  logic                     pref_valid3_i,
    input  logic                     flush_i,
    output logic                     req_valid_o,
    output logic [ADDR_W-1:0]        req_addr_o,
    input  logic                     req_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [CNT_W-1:0]         dup_cnt_o
);

    localparam int unsigned OW = $clog2(DEPTH) + 1;

    line_addr_t [NUM_SLOTS-1:0] cand_line;
    logic [NUM_SLOTS-1:0]       cand_valid;
    logic [NUM_SLOTS-1:0]       cand_dup;

    line_addr_t [NUM_SLOTS-1:0] push_data;
    logic [1:0]                 push_cnt;
    logic [1:0]                 dup_inc;
    logic [1:0]                 drop_inc;
    logic                       pop;
    logic [OW-1:0]              free_slots;

    line_addr_t                 head;
    logic [OW-1:0]              occ;
    line_addr_t [DEPTH-1:0]     entries;
    logic [DEPTH-1:0]           entry_valid;

    cnt_t                       drop_cnt_q;
    cnt_t                       dup_cnt_q;
    logic                       last_valid_q;
    line_addr_t                 last_line_q;

    // Line-align candidates before any comparison or storage.
    always_comb begin
        cand_line[0] = line_align(pref_addr1_i, LINE_BYTES);
        cand_line[1] = line_align(pref_addr2_i, LINE_BYTES);
        cand_line[2] = line_align(pref_addr3_i, LINE_BYTES);
        cand_valid   = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
    end

    // Duplicate when the line is queued, named by an earlier valid slot, or was last issued.
    always_comb begin
        cand_dup = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            logic hit;
            hit = last_valid_q && (last_line_q == cand_line[k]);
            for (int e = 0; e < DEPTH; e++) begin
                if (entry_valid[e] && (entries[e] == cand_line[k])) begin
                    hit = 1'b1;
                end
            end
            for (int j = 0; j < k; j++) begin
                if (cand_valid[j] && (cand_line[j] == cand_line[k])) begin
                    hit = 1'b1;
                end
            end
            cand_dup[k] = cand_valid[k] && hit;
        end
    end

    // Space is judged from start-of-cycle occupancy, so a same-cycle pop never frees a slot.
    assign free_slots = OW'(DEPTH) - occ;

    // Accept non-duplicates in slot priority until space runs out; count dups and drops.
    always_comb begin
        push_cnt  = 2'd0;
        push_data = '0;
        dup_inc   = 2'd0;
        drop_inc  = 2'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (cand_dup[k]) begin
                dup_inc = dup_inc + 2'd1;
            end else if (cand_valid[k]) begin
                if (OW'(push_cnt) < free_slots) begin
                    push_data[push_cnt] = cand_line[k];
                    push_cnt            = push_cnt + 2'd1;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                end
            end
        end
        if (flush_i) begin
            push_cnt = 2'd0;
            dup_inc  = 2'd0;
            drop_inc = 2'd0;
        end
    end

    assign req_valid_o = (occ != '0);
    assign req_addr_o  = req_valid_o ? head : '0;
    assign pop         = req_valid_o && req_ready_i && !flush_i;

    pref_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (flush_i),
        .push_cnt    (push_cnt),
        .push_data   (push_data),
        .pop         (pop),
        .head        (head),
        .occupancy   (occ),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    // Saturating drop/duplicate statistics; flush already zeroes the increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
            dup_cnt_q  <= sat_add(dup_cnt_q, dup_inc);
        end
    end

    // Remember the most recently issued line; flush forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid_q <= 1'b0;
            last_line_q  <= '0;
        end else if (flush_i) begin
            last_valid_q <= 1'b0;
        end else if (pop) begin
            last_valid_q <= 1'b1;
            last_line_q  <= head;
        end
    end

    assign occupancy_o = occ;
    assign drop_cnt_o  = drop_cnt_q;
    assign dup_cnt_o   = dup_cnt_q;

endmodule
